restoring_divider: RTL and testbench

//  Multi-cycle unsigned restoring divider. It computes quotient and remainder from one

---
 rtl/div_pkg.sv | 22 ++
 rtl/sub_borrow.sv | 31 +++
 rtl/restoring_divider.sv | 148 ++++++++++++++
 tb/tb_restoring_divider.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared encodings for the restoring divider slice.
// Counter width helper sizes the step counter from the operand width.
package div_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DEF_WIDTH = 4;
    localparam int CNT_W = $clog2(DEF_WIDTH + 1);

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_CALC = ST_CALC,
        S_DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/sub_borrow.sv
// (N)-bit subtractor a - b as a + ~b + 1 with generate/propagate carries.
// borrow is the inverted carry out of the top bit.
module sub_borrow #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N-1:0] nb;
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N:0]   c;

    assign nb = ~b;
    assign g  = a & nb;
    assign p  = a ^ nb;

    always_comb begin
        c[0] = 1'b1;
        for (int i = 0; i < N; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign diff   = p ^ c[N-1:0];
    assign borrow = ~c[N];

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Remainder output is registered only when DIV_REM_OUT_EN is defined.
module restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t state;
    state_t state_nx;

    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] quo_q;
    logic             dz_q;

    logic [2*WIDTH:0] rq_sh;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH:0]   r_nx;
    logic [WIDTH-1:0] q_nx;
    logic             last;
    logic             zero_go;

    // {R,Q} shifted left as one register pair
    assign rq_sh = {r, q} << 1;
    assign r_sh  = rq_sh[2*WIDTH:WIDTH];

    sub_borrow #(
        .N(WIDTH + 1)
    ) u_sub (
        .a     (r_sh),
        .b     ({1'b0, d}),
        .diff  (diff),
        .borrow(borrow)
    );

    assign r_nx    = borrow ? r_sh : diff;
    assign q_nx    = rq_sh[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, ~borrow};
    assign last    = (cnt == CW'(1));
    assign zero_go = (state == S_IDLE) && start && (divisor == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = (divisor == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (last) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            r     <= '0;
            q     <= '0;
            d     <= '0;
            quo_q <= '0;
            dz_q  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quo_q <= '1;
                            dz_q  <= 1'b1;
                        end else begin
                            d    <= divisor;
                            q    <= dividend;
                            r    <= '0;
                            cnt  <= CW'(WIDTH);
                            dz_q <= 1'b0;
                        end
                    end
                end
                S_CALC: begin
                    r   <= r_nx;
                    q   <= q_nx;
                    cnt <= cnt - CW'(1);
                    if (last) begin
                        quo_q <= q_nx;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DIV_REM_OUT_EN
    logic [WIDTH-1:0] rem_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
        end else if (zero_go) begin
            rem_q <= dividend;
        end else if ((state == S_CALC) && last) begin
            rem_q <= r_nx[WIDTH-1:0];
        end
    end

    assign remainder = rem_q;
`else
    logic unused_zero_go;

    assign unused_zero_go = zero_go;
    assign remainder      = '0;
`endif

    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign quotient    = quo_q;
    assign div_by_zero = dz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider at WIDTH=4.
// Expected results come from plain integer division in the bench.
module tb_restoring_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    restoring_divider #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] model(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] eq;
        logic [3:0] er;
        logic       edz;
        if (b == 4'd0) begin
            eq  = 4'hF;
            er  = a;
            edz = 1'b1;
        end else begin
            eq  = a / b;
            er  = a % b;
            edz = 1'b0;
        end
`ifndef DIV_REM_OUT_EN
        er = 4'd0;
`endif
        return {eq, er, edz};
    endfunction

    task automatic launch(input logic [3:0] a, input logic [3:0] b);
        @(posedge clk);
        #1;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 4'($urandom);
        divisor  = 4'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_state got=%b want=0",
                     {busy, done, quotient, remainder, div_by_zero});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic exp_done;
        launch(4'd13, 4'd4);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            exp_done = (c == 5);
            n_checks++;
            if ({busy, done} !== {1'b1, exp_done}) begin
                n_fail++;
                $display("FAIL basic_busy_done cycle=%0d got=%b want=%b",
                         c, {busy, done}, {1'b1, exp_done});
            end
        end
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== model(4'd13, 4'd4)) begin
            n_fail++;
            $display("FAIL basic_result got=%h want=%h",
                     {quotient, remainder, div_by_zero}, model(4'd13, 4'd4));
        end
        @(negedge clk);
        n_checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !==
            {2'b00, model(4'd13, 4'd4)}) begin
            n_fail++;
            $display("FAIL basic_hold got=%h want=%h",
                     {busy, done, quotient, remainder, div_by_zero},
                     {2'b00, model(4'd13, 4'd4)});
        end
    endtask

    task automatic test_values;
        logic [3:0] ta [3] = '{4'd15, 4'd3, 4'd15};
        logic [3:0] tb [3] = '{4'd1, 4'd7, 4'd15};
        int lat;
        for (int i = 0; i < 3; i++) begin
            launch(ta[i], tb[i]);
            wait_done(lat);
            n_checks++;
            if (lat != 5) begin
                n_fail++;
                $display("FAIL values_latency %0d/%0d got=%0d want=5", ta[i], tb[i], lat);
            end
            n_checks++;
            if ({quotient, remainder, div_by_zero} !== model(ta[i], tb[i])) begin
                n_fail++;
                $display("FAIL values_result %0d/%0d got=%h want=%h", ta[i], tb[i],
                         {quotient, remainder, div_by_zero}, model(ta[i], tb[i]));
            end
        end
    endtask

    task automatic test_zero_divisor;
        int lat;
        launch(4'd9, 4'd0);
        wait_done(lat);
        n_checks++;
        if (lat != 1) begin
            n_fail++;
            $display("FAIL zero_latency got=%0d want=1", lat);
        end
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== model(4'd9, 4'd0)) begin
            n_fail++;
            $display("FAIL zero_result got=%h want=%h",
                     {quotient, remainder, div_by_zero}, model(4'd9, 4'd0));
        end
        @(negedge clk);
        n_checks++;
        if ({busy, quotient, div_by_zero} !== {1'b0, 4'hF, 1'b1}) begin
            n_fail++;
            $display("FAIL zero_hold got=%b want=%b",
                     {busy, quotient, div_by_zero}, {1'b0, 4'hF, 1'b1});
        end
        launch(4'd6, 4'd3);
        wait_done(lat);
        n_checks++;
        if (lat != 5) begin
            n_fail++;
            $display("FAIL zero_next_latency got=%0d want=5", lat);
        end
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== model(4'd6, 4'd3)) begin
            n_fail++;
            $display("FAIL zero_next_result got=%h want=%h",
                     {quotient, remainder, div_by_zero}, model(4'd6, 4'd3));
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        logic seen_done;
        launch(4'd13, 4'd4);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async got=%b want=0",
                     {busy, done, quotient, remainder, div_by_zero});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done !== 1'b0) seen_done = 1'b1;
        end
        n_checks++;
        if (seen_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done got=%b want=0", seen_done);
        end
        launch(4'd10, 4'd3);
        wait_done(lat);
        n_checks++;
        if (lat != 5) begin
            n_fail++;
            $display("FAIL reset_mid_latency got=%0d want=5", lat);
        end
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== model(4'd10, 4'd3)) begin
            n_fail++;
            $display("FAIL reset_mid_result got=%h want=%h",
                     {quotient, remainder, div_by_zero}, model(4'd10, 4'd3));
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        @(posedge clk);
        #1;
        dividend = 4'd13;
        divisor  = 4'd4;
        start    = 1'b1;
        @(posedge clk);
        #1;
        dividend = 4'd2;
        divisor  = 4'd1;
        wait_done(lat);
        n_checks++;
        if (lat != 5) begin
            n_fail++;
            $display("FAIL b2b_first_latency got=%0d want=5", lat);
        end
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== model(4'd13, 4'd4)) begin
            n_fail++;
            $display("FAIL b2b_first_result got=%h want=%h",
                     {quotient, remainder, div_by_zero}, model(4'd13, 4'd4));
        end
        dividend = 4'd14;
        divisor  = 4'd5;
        wait_done(lat);
        start = 1'b0;
        n_checks++;
        if (lat != 6) begin
            n_fail++;
            $display("FAIL b2b_second_latency got=%0d want=6", lat);
        end
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== model(4'd14, 4'd5)) begin
            n_fail++;
            $display("FAIL b2b_second_result got=%h want=%h",
                     {quotient, remainder, div_by_zero}, model(4'd14, 4'd5));
        end
    endtask

    task automatic test_random;
        logic [3:0] a;
        logic [3:0] b;
        int lat;
        for (int i = 0; i < 30; i++) begin
            a = 4'($urandom);
            b = 4'($urandom);
            launch(a, b);
            wait_done(lat);
            n_checks++;
            if (lat != ((b == 4'd0) ? 1 : 5)) begin
                n_fail++;
                $display("FAIL random_latency %0d/%0d got=%0d", a, b, lat);
            end
            n_checks++;
            if ({quotient, remainder, div_by_zero} !== model(a, b)) begin
                n_fail++;
                $display("FAIL random_result %0d/%0d got=%h want=%h", a, b,
                         {quotient, remainder, div_by_zero}, model(a, b));
            end
        end
    endtask

    task automatic test_sweep;
        int lat;
        int qi;
        int ri;
        logic ok;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                launch(4'(a), 4'(b));
                wait_done(lat);
                n_checks++;
                if ({quotient, remainder, div_by_zero} !== model(4'(a), 4'(b))) begin
                    n_fail++;
                    $display("FAIL sweep_result %0d/%0d got=%h want=%h", a, b,
                             {quotient, remainder, div_by_zero}, model(4'(a), 4'(b)));
                end
                if (b != 0) begin
                    qi = int'(quotient);
                    ri = int'(remainder);
`ifdef DIV_REM_OUT_EN
                    ok = (qi * b + ri == a) && (ri < b);
`else
                    ok = (ri == 0) && (qi == a / b);
`endif
                    n_checks++;
                    if (ok !== 1'b1) begin
                        n_fail++;
                        $display("FAIL sweep_identity %0d/%0d got q=%0d r=%0d", a, b, qi, ri);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_values();
        test_zero_divisor();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
